dcache_responder: RTL and testbench
===================================

# dcache_responder

Direct-mapped, write-through, no-write-allocate data cache that answers the MEM stage's load/store requests and drives the single-port backing RAM. It sits between the MEM stage and data RAM and supplies read data plus the hit flag the MEM stage stalls on. Stores are absorbed into a small write buffer so they normally complete without a stall. Loads that hit return data combinationally. Loads that miss hold the hit flag low until a line fill from RAM completes.

## Interface
- INDEX_BITS, 4, line-index width; 2^INDEX_BITS one-word lines
- WB_DEPTH, 4, write-buffer entries (power of 2, ≥2)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_ce_i  in  1  request valid from MEM stage
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  byte address; bits [1:0] ignored
- mem_sel_i  in  4  byte enables for stores (bit n = byte lane n)
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data
- is_hit_o  out  1  request served this cycle; 0 = MEM stage must stall and hold its request
- ram_ce_o  out  1  RAM request valid
- ram_we_o  out  1  RAM write
- ram_addr_o  out  32  RAM word address (bits [1:0] = 0)
- ram_sel_o  out  4  RAM byte enables
- ram_data_o  out  32  RAM write data
- ram_data_i  in  32  RAM read data, valid with ram_ack_i
- ram_ack_i  in  1  one-cycle RAM completion pulse

## Operation
- Address split: index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2]. Per line: valid bit, tag, 32-bit data.
- mem_ce_i = 0: is_hit_o = 1, mem_data_o = 0, no state change.
- Load, line valid and tag match: is_hit_o = 1, mem_data_o = line data, same cycle.
- Load miss: is_hit_o = 0, mem_data_o = 0. A fill starts only when the write buffer is empty; drain-before-fill guarantees the fill reads current data.
- Store, buffer not full: is_hit_o = 1. At the clock edge, {addr, sel, data} is enqueued. If the line is valid with a matching tag, the bytes selected by mem_sel_i are merged into the line. On a miss, the line is untouched.
- Store, buffer full (count == WB_DEPTH, evaluated before any same-cycle pop): is_hit_o = 0, no enqueue, no line update.
- FSM states: IDLE, DRAIN, FILL.
  - IDLE, buffer non-empty -> DRAIN. Drain has priority over fill.
  - IDLE, buffer empty and a load miss present -> FILL. The request word address is latched on entry.
  - DRAIN: ram_ce_o = 1, ram_we_o = 1; addr/sel/data = buffer head, held stable until ram_ack_i. On ack, pop the head and go to IDLE.
  - FILL: ram_ce_o = 1, ram_we_o = 0, ram_sel_o = 4'b1111, ram_addr_o = latched address, held until ram_ack_i. On ack, write the line (valid = 1, tag, ram_data_i) and go to IDLE.
- ram_ack_i is ignored in IDLE.
- In IDLE, ram_ce_o = 0, ram_we_o = 0, and ram_addr_o/sel/data = 0.
- Write buffer is a circular FIFO with head/tail pointers that wrap modulo WB_DEPTH and a count of width log2(WB_DEPTH)+1. Enqueue and pop in the same cycle leave the count unchanged.

## Timing
- Reset (rst_n low, asynchronous): all valid bits = 0, buffer empty, pointers = 0, state = IDLE. While low: ram_ce_o = 0, ram_we_o = 0, ram_addr_o = 0, ram_sel_o = 0, ram_data_o = 0, mem_data_o = 0, is_hit_o = 0.
- Reset mid-DRAIN or mid-FILL: the transaction is abandoned and buffered stores are lost. Any late ram_ack_i after release is ignored (state is IDLE).
- Load hit: 0-cycle latency.
- Load miss, buffer empty, miss seen in cycle 0:
  - FILL entered at the cycle-1 edge; ram_ce_o high from cycle 1.
  - Ack in cycle k ≥ 1 writes the line at that edge.
  - is_hit_o = 1 with data in cycle k+1.
  - Minimum stall is 2 cycles.
- Each DRAIN occupies ≥1 cycle plus 1 IDLE cycle, so sustained drain is at most 1 store per 2 cycles with single-cycle acks.
- RAM outputs change only on clock edges (registered state). is_hit_o and mem_data_o are combinational from inputs and state.

## Test plan
- Reset, then load 0x00000040 with ack 3 cycles after ram_ce_o:
  - ram_ce_o=1, ram_we_o=0, ram_addr_o=0x40 until ack.
  - is_hit_o=0 until the cycle after ack, then 1 with mem_data_o = returned 0xDEADBEEF.
  - A repeat load hits with zero stall.
- Store to resident 0x40, sel=4'b0011, data 0x12345678:
  - is_hit_o=1 the same cycle.
  - A following load returns 0xDEAD5678.
  - RAM then sees a write of addr 0x40, sel 0011.
- 5 back-to-back stores to missing lines with RAM ack withheld:
  - Stores 1–4 are accepted.
  - The 5th has is_hit_o=0 until the first ack pops an entry.
  - All 5 writes reach RAM in order.
- Store to missing 0x80, then immediately load 0x80:
  - The load stalls until the drain ack.
  - The fill starts only after the drain and returns the stored value.
- Conflict: load 0x40, then load 0x80 (same index, INDEX_BITS=4):
  - The second load misses and refills.
  - A reload of 0x40 misses again.
- Assert rst_n low during FILL:
  - All outputs go to 0 immediately.
  - After release, a late ram_ack_i is ignored, and a load of the previously filled address misses.

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped write-through data cache with a store buffer in front of a single-port RAM.
// Loads hit combinationally; misses fill one word after the store buffer has drained.
module dcache_responder #(
    parameter int INDEX_BITS = 4,
    parameter int WB_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        is_hit_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_ack_i
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q   [LINES];
    logic [TAG_W-1:0]  tag_d   [LINES];
    logic [31:0]       line_q  [LINES];
    logic [31:0]       line_d  [LINES];
    logic [29:0]       wb_addr_q [WB_DEPTH];
    logic [29:0]       wb_addr_d [WB_DEPTH];
    logic [3:0]        wb_sel_q  [WB_DEPTH];
    logic [3:0]        wb_sel_d  [WB_DEPTH];
    logic [31:0]       wb_data_q [WB_DEPTH];
    logic [31:0]       wb_data_d [WB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ram_ce_q, ram_ce_d, ram_we_q, ram_we_d;
    logic [31:0]       ram_addr_q, ram_addr_d, ram_data_q, ram_data_d;
    logic [3:0]        ram_sel_q, ram_sel_d;

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  line_hit, wb_full, store_ok, pop;

    assign req_idx  = mem_addr_i[INDEX_BITS+1:2];
    assign req_tag  = mem_addr_i[31:INDEX_BITS+2];
    assign fill_idx = ram_addr_q[INDEX_BITS+1:2];
    assign line_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign wb_full  = (count_q == CNT_W'(WB_DEPTH));
    assign store_ok = mem_ce_i && mem_we_i && !wb_full;

    assign ram_ce_o   = ram_ce_q;
    assign ram_we_o   = ram_we_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_sel_o  = ram_sel_q;
    assign ram_data_o = ram_data_q;

    always_comb begin
        is_hit_o   = 1'b0;
        mem_data_o = 32'h0;
        if (rst_n) begin
            if (!mem_ce_i) begin
                is_hit_o = 1'b1;
            end else if (mem_we_i) begin
                is_hit_o = !wb_full;
            end else if (line_hit) begin
                is_hit_o   = 1'b1;
                mem_data_o = line_q[req_idx];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        line_d     = line_q;
        wb_addr_d  = wb_addr_q;
        wb_sel_d   = wb_sel_q;
        wb_data_d  = wb_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        ram_ce_d   = ram_ce_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_sel_d  = ram_sel_q;
        ram_data_d = ram_data_q;
        pop        = 1'b0;

        if (store_ok) begin
            wb_addr_d[tail_q] = mem_addr_i[31:2];
            wb_sel_d[tail_q]  = mem_sel_i;
            wb_data_d[tail_q] = mem_data_i;
            tail_d            = tail_q + 1'b1;
            // Keep a resident line coherent with the store that is heading to RAM.
            if (line_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_sel_i[b]) line_d[req_idx][8*b +: 8] = mem_data_i[8*b +: 8];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d    = DRAIN;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = {wb_addr_q[head_q], 2'b00};
                    ram_sel_d  = wb_sel_q[head_q];
                    ram_data_d = wb_data_q[head_q];
                end else if (mem_ce_i && !mem_we_i && !line_hit) begin
                    state_d    = FILL;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = {mem_addr_i[31:2], 2'b00};
                    ram_sel_d  = 4'b1111;
                    ram_data_d = 32'h0;
                end
            end
            DRAIN: begin
                if (ram_ack_i) begin
                    pop        = 1'b1;
                    head_d     = head_q + 1'b1;
                    state_d    = IDLE;
                    ram_ce_d   = 1'b0;
                    ram_we_d   = 1'b0;
                    ram_addr_d = 32'h0;
                    ram_sel_d  = 4'b0;
                    ram_data_d = 32'h0;
                end
            end
            FILL: begin
                if (ram_ack_i) begin
                    valid_d[fill_idx] = 1'b1;
                    tag_d[fill_idx]   = ram_addr_q[31:INDEX_BITS+2];
                    line_d[fill_idx]  = ram_data_i;
                    state_d           = IDLE;
                    ram_ce_d          = 1'b0;
                    ram_we_d          = 1'b0;
                    ram_addr_d        = 32'h0;
                    ram_sel_d         = 4'b0;
                    ram_data_d        = 32'h0;
                end
            end
            default: state_d = IDLE;
        endcase

        count_d = count_q + CNT_W'(store_ok) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 32'h0;
            ram_sel_q  <= 4'b0;
            ram_data_q <= 32'h0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                line_q[i] <= 32'h0;
            end
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= 30'h0;
                wb_sel_q[i]  <= 4'b0;
                wb_data_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            line_q     <= line_d;
            wb_addr_q  <= wb_addr_d;
            wb_sel_q   <= wb_sel_d;
            wb_data_q  <= wb_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ram_ce_q   <= ram_ce_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_sel_q  <= ram_sel_d;
            ram_data_q <= ram_data_d;
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a behavioural single-port RAM that logs writes.
`timescale 1ns/1ps
module tb_dcache_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ce_i = 1'b0, mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = 32'h0, mem_data_i = 32'h0;
    logic [3:0]  mem_sel_i = 4'h0;
    logic [31:0] mem_data_o;
    logic        is_hit_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_i = 32'h0;
    logic        ram_ack_i = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic [3:0]  log_sel  [$];
    logic [31:0] log_data [$];
    bit ram_hold = 0;
    bit ram_manual = 0;
    int ack_delay = 0;

    dcache_responder dut (
        .clk(clk), .rst_n(rst_n),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
        .mem_data_o(mem_data_o), .is_hit_o(is_hit_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i)
    );

    always #5 clk = ~clk;

    // RAM: acks ack_delay cycles after it first sees ram_ce_o, unless held or overridden.
    initial begin : ram_model
        logic [31:0] w;
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!ram_manual) begin
                ram_ack_i  = 1'b0;
                ram_data_i = 32'h0;
                if (ram_ce_o && !ram_hold) begin
                    if (wait_cnt >= ack_delay) begin
                        wait_cnt  = 0;
                        ram_ack_i = 1'b1;
                        w = ram_mem.exists(ram_addr_o) ? ram_mem[ram_addr_o] : 32'h0;
                        if (ram_we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (ram_sel_o[b]) w[8*b +: 8] = ram_data_o[8*b +: 8];
                            ram_mem[ram_addr_o] = w;
                            log_addr.push_back(ram_addr_o);
                            log_sel.push_back(ram_sel_o);
                            log_data.push_back(ram_data_o);
                        end else begin
                            ram_data_i = w;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end else if (!ram_ce_o) begin
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_addr.delete(); log_sel.delete(); log_data.delete();
    endtask

    task automatic run_load(input logic [31:0] addr, output bit hit_first,
                            output logic [31:0] data, output int stall);
        cyc();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = addr; mem_sel_i = 4'h0;
        #1;
        hit_first = is_hit_o;
        stall = 0;
        while (!is_hit_o && stall < 40) begin
            stall++;
            cyc(); #1;
        end
        if (!is_hit_o) stall = -1;
        data = mem_data_o;
    endtask

    task automatic test_reset();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40;
        #3;
        checks++; if (is_hit_o !== 1'b0) begin errors++; $display("FAIL reset_is_hit got=%b exp=0", is_hit_o); end
        checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL reset_mem_data got=%h exp=0", mem_data_o); end
        checks++; if ({ram_ce_o, ram_we_o, ram_sel_o} !== 6'b0) begin errors++; $display("FAIL reset_ram_ctl got=%b exp=0", {ram_ce_o, ram_we_o, ram_sel_o}); end
        checks++; if ({ram_addr_o, ram_data_o} !== 64'h0) begin errors++; $display("FAIL reset_ram_bus got=%h exp=0", {ram_addr_o, ram_data_o}); end
        mem_ce_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        checks++; if (is_hit_o !== 1'b1) begin errors++; $display("FAIL idle_is_hit got=%b exp=1", is_hit_o); end
    endtask

    task automatic test_fill();
        int stall;
        ram_mem[32'h40] = 32'hDEADBEEF;
        ack_delay = 3;
        cyc();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40;
        #1;
        checks++; if (is_hit_o !== 1'b0) begin errors++; $display("FAIL fill_first_miss got=%b exp=0", is_hit_o); end
        stall = 0;
        while (!is_hit_o && stall < 40) begin
            stall++;
            cyc(); #1;
            if (!is_hit_o) begin
                checks++;
                if ({ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h40}) begin
                    errors++;
                    $display("FAIL fill_ram_req cycle=%0d got ce=%b we=%b sel=%h addr=%h exp ce=1 we=0 sel=f addr=00000040",
                             stall, ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o);
                end
            end
        end
        checks++; if (stall !== 5) begin errors++; $display("FAIL fill_stall got=%0d exp=5", stall); end
        checks++; if (mem_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL fill_data got=%h exp=deadbeef", mem_data_o); end
        checks++; if (ram_ce_o !== 1'b0) begin errors++; $display("FAIL fill_ram_release got=%b exp=0", ram_ce_o); end
        cyc();
        mem_addr_i = 32'h40;
        #1;
        checks++; if ({is_hit_o, mem_data_o} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL repeat_hit got=%b/%h exp=1/deadbeef", is_hit_o, mem_data_o); end
    endtask

    task automatic test_store_merge();
        int n;
        ack_delay = 0;
        clear_log();
        cyc();
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h40; mem_sel_i = 4'b0011; mem_data_i = 32'h12345678;
        #1;
        checks++; if (is_hit_o !== 1'b1) begin errors++; $display("FAIL store_accept got=%b exp=1", is_hit_o); end
        cyc();
        mem_we_i = 1'b0; mem_sel_i = 4'h0;
        #1;
        checks++; if ({is_hit_o, mem_data_o} !== {1'b1, 32'hDEAD5678}) begin errors++; $display("FAIL merge_load got=%b/%h exp=1/dead5678", is_hit_o, mem_data_o); end
        cyc();
        mem_ce_i = 1'b0;
        n = 0;
        while (log_addr.size() < 1 && n < 20) begin cyc(); n++; end
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL merge_write_count got=%0d exp=1", log_addr.size()); end
        if (log_addr.size() > 0) begin
            checks++;
            if ({log_addr[0], log_sel[0], log_data[0]} !== {32'h40, 4'b0011, 32'h12345678}) begin
                errors++;
                $display("FAIL merge_write got addr=%h sel=%b data=%h exp addr=00000040 sel=0011 data=12345678",
                         log_addr[0], log_sel[0], log_data[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_log();
        ram_hold = 1;
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h104 + 32'(4 * i);
            mem_sel_i = 4'hF; mem_data_i = 32'hA0000000 + 32'(i);
            #1;
            checks++; if (is_hit_o !== 1'b1) begin errors++; $display("FAIL wb_accept%0d got=%b exp=1", i, is_hit_o); end
        end
        cyc();
        mem_addr_i = 32'h114; mem_data_i = 32'hA0000004;
        #1;
        checks++; if (is_hit_o !== 1'b0) begin errors++; $display("FAIL wb_full_stall got=%b exp=0", is_hit_o); end
        cyc(); #1;
        checks++; if (is_hit_o !== 1'b0) begin errors++; $display("FAIL wb_full_held got=%b exp=0", is_hit_o); end
        ram_hold = 0;
        n = 0;
        while (!is_hit_o && n < 20) begin cyc(); #1; n++; end
        checks++; if (is_hit_o !== 1'b1) begin errors++; $display("FAIL wb_5th_accept got=%b exp=1", is_hit_o); end
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL wb_accept_after_one_pop got=%0d exp=1", log_addr.size()); end
        cyc();
        mem_ce_i = 1'b0;
        n = 0;
        while (log_addr.size() < 5 && n < 40) begin cyc(); n++; end
        checks++; if (log_addr.size() !== 5) begin errors++; $display("FAIL wb_write_count got=%0d exp=5", log_addr.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < log_addr.size()) begin
                checks++;
                if ({log_addr[i], log_data[i]} !== {32'h104 + 32'(4 * i), 32'hA0000000 + 32'(i)}) begin
                    errors++;
                    $display("FAIL wb_order%0d got addr=%h data=%h exp addr=%h data=%h", i, log_addr[i], log_data[i],
                             32'h104 + 32'(4 * i), 32'hA0000000 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_drain_before_fill();
        int n;
        bit fill_seen;
        clear_log();
        ack_delay = 1;
        cyc();
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h80; mem_sel_i = 4'hF; mem_data_i = 32'hCAFEF00D;
        #1;
        checks++; if (is_hit_o !== 1'b1) begin errors++; $display("FAIL dbf_store got=%b exp=1", is_hit_o); end
        cyc();
        mem_we_i = 1'b0; mem_sel_i = 4'h0;
        #1;
        checks++; if (is_hit_o !== 1'b0) begin errors++; $display("FAIL dbf_load_miss got=%b exp=0", is_hit_o); end
        fill_seen = 0;
        n = 0;
        while (!is_hit_o && n < 40) begin
            cyc(); #1; n++;
            if (ram_ce_o && !ram_we_o && !fill_seen) begin
                fill_seen = 1;
                checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL dbf_drain_first got=%0d exp=1", log_addr.size()); end
                checks++; if (ram_addr_o !== 32'h80) begin errors++; $display("FAIL dbf_fill_addr got=%h exp=00000080", ram_addr_o); end
            end
        end
        checks++; if (fill_seen !== 1'b1) begin errors++; $display("FAIL dbf_fill_seen got=%b exp=1", fill_seen); end
        checks++; if ({is_hit_o, mem_data_o} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL dbf_data got=%b/%h exp=1/cafef00d", is_hit_o, mem_data_o); end
    endtask

    task automatic test_conflict();
        bit hf;
        logic [31:0] d;
        int st;
        ack_delay = 0;
        run_load(32'h40, hf, d, st);
        checks++; if ({hf, d} !== {1'b0, 32'hDEAD5678}) begin errors++; $display("FAIL conf_a got=%b/%h exp=0/dead5678", hf, d); end
        checks++; if (st !== 2) begin errors++; $display("FAIL conf_min_stall got=%0d exp=2", st); end
        run_load(32'h80, hf, d, st);
        checks++; if ({hf, d} !== {1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL conf_b got=%b/%h exp=0/cafef00d", hf, d); end
        run_load(32'h40, hf, d, st);
        checks++; if ({hf, d} !== {1'b0, 32'hDEAD5678}) begin errors++; $display("FAIL conf_a_again got=%b/%h exp=0/dead5678", hf, d); end
        cyc();
        mem_ce_i = 1'b0;
    endtask

    task automatic test_reset_during_fill();
        bit hf;
        logic [31:0] d;
        int st;
        ram_hold = 1;
        cyc();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300;
        #1;
        checks++; if (is_hit_o !== 1'b0) begin errors++; $display("FAIL rf_miss got=%b exp=0", is_hit_o); end
        cyc(); #1;
        checks++; if ({ram_ce_o, ram_addr_o} !== {1'b1, 32'h300}) begin errors++; $display("FAIL rf_fill_active got=%b/%h exp=1/00000300", ram_ce_o, ram_addr_o); end
        cyc(); #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({ram_ce_o, ram_we_o, ram_sel_o, is_hit_o} !== 7'b0) begin errors++; $display("FAIL rf_ctl_zero got=%b exp=0", {ram_ce_o, ram_we_o, ram_sel_o, is_hit_o}); end
        checks++; if ({ram_addr_o, ram_data_o, mem_data_o} !== 96'h0) begin errors++; $display("FAIL rf_bus_zero got=%h exp=0", {ram_addr_o, ram_data_o, mem_data_o}); end
        ram_manual = 1;
        ram_hold = 0;
        mem_ce_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cyc();
        ram_ack_i = 1'b1; ram_data_i = 32'h55555555;
        cyc();
        ram_ack_i = 1'b0; ram_data_i = 32'h0;
        #1;
        checks++; if (ram_ce_o !== 1'b0) begin errors++; $display("FAIL rf_late_ack got=%b exp=0", ram_ce_o); end
        ram_manual = 0;
        run_load(32'h40, hf, d, st);
        checks++; if (hf !== 1'b0) begin errors++; $display("FAIL rf_invalidated got=%b exp=0", hf); end
        checks++; if (d !== 32'hDEAD5678) begin errors++; $display("FAIL rf_refill_data got=%h exp=dead5678", d); end
        cyc();
        mem_ce_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_merge();
        test_back_to_back();
        test_drain_before_fill();
        test_conflict();
        test_reset_during_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
